// File: rtl/alu_pkg.sv
// Shared ALU types and defaults.
// Used by the serial subtract path and its 1-bit cell.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int ALU_WIDTH_DEF = 4;

endpackage

// File: rtl/full_subtractor_1.sv
// 1-bit full subtractor cell: d = i - j - bin.
// Subtract counterpart of the 1-bit adder cell.
module full_subtractor_1 (
  input  logic i,
  input  logic j,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = i ^ j ^ bin;
  assign bout = (~i & j) | (~(i ^ j) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first.
// One full-subtractor cell plus a borrow flop; valid/ready on both sides.
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t state_q, state_d;

  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-2:0] p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             brw_q, brw_d;
  logic             ovf_q, ovf_d;
  logic             zro_q, zro_d;

  logic             d_bit;
  logic             bo_bit;
  logic [WIDTH-1:0] q_next;
  logic             accept;
  logic             run;
  logic             last;

  full_subtractor_1 u_fs (
    .i    (a_sr_q[0]),
    .j    (b_sr_q[0]),
    .bin  (bor_q),
    .d    (d_bit),
    .bout (bo_bit)
  );

  // p_q holds the low result bits gathered so far, packed at its top end
  assign q_next = {d_bit, p_q};
  assign accept = (state_q == IDLE) & in_valid;
  assign run    = (state_q == RUN);
  assign last   = run & (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = RUN;
      RUN:  if (cnt_q == LAST) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    p_d     = p_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    bor_d   = bor_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    brw_d   = brw_q;
    ovf_d   = ovf_q;
    zro_d   = zro_q;
    unique case (1'b1)
      accept: begin
        a_sr_d  = a;
        b_sr_d  = b;
        a_msb_d = a[WIDTH-1];
        b_msb_d = b[WIDTH-1];
        bor_d   = 1'b0;
        cnt_d   = '0;
      end
      run: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        p_d    = q_next[WIDTH-1:1];
        bor_d  = bo_bit;
        if (!last) cnt_d = cnt_q + CW'(1);
        if (last) begin
          q_d   = q_next;
          brw_d = bo_bit;
          ovf_d = (a_msb_q != b_msb_q) & (d_bit != a_msb_q);
          zro_d = (q_next == '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      p_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      bor_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      brw_q   <= 1'b0;
      ovf_q   <= 1'b0;
      zro_q   <= 1'b0;
    end else begin
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      p_q     <= p_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      bor_q   <= bor_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      brw_q   <= brw_d;
      ovf_q   <= ovf_d;
      zro_q   <= zro_d;
    end
  end

  assign q          = q_q;
  assign borrow_out = brw_q;
  assign overflow   = ovf_q;
  assign zero       = zro_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=4 and WIDTH=8.
// Expected values are hand-computed or from an arithmetic model.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;

  logic       in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0] a4, b4, q4;
  logic       brw4, ovf4, zro4;

  logic       in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0] a8, b8, q8;
  logic       brw8, ovf8, zro8;

  int vectors;
  int fails;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid4),
    .in_ready   (in_ready4),
    .a          (a4),
    .b          (b4),
    .out_valid  (out_valid4),
    .out_ready  (out_ready4),
    .q          (q4),
    .borrow_out (brw4),
    .overflow   (ovf4),
    .zero       (zro4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid8),
    .in_ready   (in_ready8),
    .a          (a8),
    .b          (b8),
    .out_valid  (out_valid8),
    .out_ready  (out_ready8),
    .q          (q8),
    .borrow_out (brw8),
    .overflow   (ovf8),
    .zero       (zro8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start4(input logic [3:0] x, input logic [3:0] y);
    a4 = x;
    b4 = y;
    in_valid4 = 1'b1;
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    a4 = ~x;
    b4 = ~y;
  endtask

  task automatic wait4(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid4 && lat < 20);
  endtask

  task automatic res4(input string tag, input logic [3:0] eq,
                      input logic eb, input logic eo, input logic ez);
    chk({tag, "_q"}, 32'(q4), 32'(eq));
    chk({tag, "_borrow"}, 32'(brw4), 32'(eb));
    chk({tag, "_ovf"}, 32'(ovf4), 32'(eo));
    chk({tag, "_zero"}, 32'(zro4), 32'(ez));
  endtask

  task automatic release4(input string tag);
    out_ready4 = 1'b1;
    @(posedge clk);
    #1;
    out_ready4 = 1'b0;
    chk({tag, "_vld_drop"}, 32'(out_valid4), 32'd0);
    chk({tag, "_rdy_back"}, 32'(in_ready4), 32'd1);
  endtask

  task automatic op4(input string tag, input logic [3:0] x,
                     input logic [3:0] y, input logic [3:0] eq,
                     input logic eb, input logic eo, input logic ez);
    int lat;
    start4(x, y);
    wait4(lat);
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    res4(tag, eq, eb, eo, ez);
    release4(tag);
  endtask

  initial begin
    int lat;
    int n;
    logic seen;
    logic [7:0] xa, xb, ed;
    vectors = 0;
    fails = 0;
    rst_n = 1'b0;
    in_valid4 = 1'b0;
    out_ready4 = 1'b0;
    a4 = '0;
    b4 = '0;
    in_valid8 = 1'b0;
    out_ready8 = 1'b0;
    a8 = '0;
    b8 = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 32'(out_valid4), 32'd0);
    chk("rst_q", 32'(q4), 32'd0);
    chk("rst_flags", 32'({brw4, ovf4, zro4}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rdy", 32'(in_ready4), 32'd1);

    op4("t1", 4'd5, 4'd3, 4'd2, 1'b0, 1'b0, 1'b0);
    op4("t2", 4'd3, 4'd5, 4'hE, 1'b1, 1'b0, 1'b0);
    op4("t3a", 4'h8, 4'h1, 4'h7, 1'b0, 1'b1, 1'b0);
    op4("t3b", 4'h7, 4'hF, 4'h8, 1'b1, 1'b1, 1'b0);

    start4(4'd7, 4'd7);
    chk("t4_busy", 32'(in_ready4), 32'd0);
    wait4(lat);
    chk("t4_lat", 32'(lat), 32'd4);
    res4("t4", 4'd0, 1'b0, 1'b0, 1'b1);
    in_valid4 = 1'b1;
    a4 = 4'd1;
    b4 = 4'd0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("t4_hold_vld", 32'(out_valid4), 32'd1);
      chk("t4_hold_q", 32'(q4), 32'd0);
      chk("t4_hold_rdy", 32'(in_ready4), 32'd0);
    end
    in_valid4 = 1'b0;
    chk("t4_hold_zero", 32'(zro4), 32'd1);
    release4("t4");

    start4(4'd6, 4'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rdy", 32'(in_ready4), 32'd1);
    chk("t5_vld", 32'(out_valid4), 32'd0);
    chk("t5_q", 32'(q4), 32'd0);
    chk("t5_zero", 32'(zro4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      seen |= out_valid4;
    end
    chk("t5_no_result", 32'(seen), 32'd0);
    op4("t5_next", 4'd9, 4'd2, 4'd7, 1'b0, 1'b1, 1'b0);

    out_ready8 = 1'b1;
    in_valid8 = 1'b1;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    for (int p = 0; p < 256; p++) begin
      n = 0;
      while (!in_ready8 && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("t6_rdy", 32'(in_ready8), 32'd1);
      chk("t6_one_done", 32'(out_valid8), 32'd0);
      xa = a8;
      xb = b8;
      @(posedge clk);
      #1;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      lat = 0;
      do begin
        @(posedge clk);
        #1;
        lat++;
      end while (!out_valid8 && lat < 20);
      ed = xa - xb;
      chk("t6_lat", 32'(lat), 32'd8);
      chk("t6_q", 32'(q8), 32'(ed));
      chk("t6_borrow", 32'(brw8), 32'(xa < xb));
      chk("t6_ovf", 32'(ovf8),
          32'((xa[7] != xb[7]) && (ed[7] != xa[7])));
      chk("t6_zero", 32'(zro8), 32'(ed == 8'd0));
      a8 = 8'($urandom);
      b8 = 8'($urandom);
    end
    in_valid8 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
